// File: rtl/godai_run_monitor.sv
// godai_run_monitor: end-of-run detector (signature + repeated halt fetch), pass/fail, counters; optional watchdog via GODAI_RUN_MONITOR_TIMEOUT_EN
module godai_run_monitor #(
    parameter int unsigned                  DATA_WIDTH     = 32,
    parameter int unsigned                  REG_IDX_WIDTH  = 5,
    parameter int unsigned                  SIG_REG        = 13,
    parameter logic [DATA_WIDTH-1:0]        SIG_VALUE      = 32'hBD8528BE,
    parameter logic [DATA_WIDTH-1:0]        HALT_INSTR     = 32'h0000006F,
    parameter int unsigned                  HALT_REPEAT    = 1,
    parameter int unsigned                  CNT_WIDTH      = 32,
    parameter int unsigned                  TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable_i,
    input  logic                     instr_rvalid_i,
    input  logic [DATA_WIDTH-1:0]    instr_rdata_i,
    input  logic                     rf_we_i,
    input  logic [REG_IDX_WIDTH-1:0] rf_waddr_i,
    input  logic [DATA_WIDTH-1:0]    rf_wdata_i,
    output logic                     done_o,
    output logic                     pass_o,
    output logic                     fail_o,
    output logic                     timeout_o,
    output logic                     armed_o,
    output logic [CNT_WIDTH-1:0]     cycle_count_o,
    output logic [CNT_WIDTH-1:0]     fetch_count_o
);
    typedef enum logic [1:0] {IDLE, RUN, ARMED, DONE} state_t;
    state_t               state, state_nx, live_nx;
    logic [3:0]           halt_cnt, halt_nx, halt_step;
    logic [CNT_WIDTH-1:0] cycle_cnt, cycle_nx, fetch_cnt, fetch_nx;
    logic                 pass_q, pass_nx, fail_q, fail_nx, timeout_q, timeout_nx;
    logic                 sig_wr, sig_match, halt_beat, armed_eff, halt_fin;
    assign sig_wr    = rf_we_i && rf_waddr_i == REG_IDX_WIDTH'(SIG_REG);
    assign sig_match = sig_wr && rf_wdata_i == SIG_VALUE;
    assign halt_beat = instr_rvalid_i && instr_rdata_i == HALT_INSTR;
    assign done_o        = state == DONE;
    assign armed_o       = state == ARMED;
    assign pass_o        = pass_q;
    assign fail_o        = fail_q;
    assign timeout_o     = timeout_q;
    assign cycle_count_o = cycle_cnt;
    assign fetch_count_o = fetch_cnt;
    // next state: this cycle's register write settles armed-ness before the halt streak is judged
    always_comb begin
        state_nx   = state;
        halt_nx    = halt_cnt;
        cycle_nx   = cycle_cnt;
        fetch_nx   = fetch_cnt;
        pass_nx    = pass_q;
        fail_nx    = fail_q;
        timeout_nx = timeout_q;
        armed_eff  = sig_match || (state == ARMED && !sig_wr);
        halt_step  = !instr_rvalid_i ? halt_cnt : halt_beat ? halt_cnt + 4'd1 : 4'd0;
        halt_fin   = halt_step == 4'(HALT_REPEAT);
        live_nx    = armed_eff ? ARMED : RUN;
        if (state == IDLE) begin
            if (enable_i) state_nx = RUN;
        end else if (state != DONE && enable_i) begin
            cycle_nx = &cycle_cnt ? cycle_cnt : cycle_cnt + CNT_WIDTH'(1);
            fetch_nx = (instr_rvalid_i && !(&fetch_cnt)) ? fetch_cnt + CNT_WIDTH'(1) : fetch_cnt;
            if (halt_fin) begin
                state_nx = DONE;
                halt_nx  = 4'd0;
                pass_nx  = armed_eff;
                fail_nx  = !armed_eff;
`ifdef GODAI_RUN_MONITOR_TIMEOUT_EN
            end else if (cycle_nx == CNT_WIDTH'(TIMEOUT_CYCLES)) begin
                state_nx   = DONE;
                halt_nx    = 4'd0;
                fail_nx    = 1'b1;
                timeout_nx = 1'b1;
`endif
            end else begin
                state_nx = live_nx;
                halt_nx  = live_nx != state ? 4'd0 : halt_step;
            end
        end
    end
    // state and counter registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            halt_cnt  <= 4'd0;
            cycle_cnt <= '0;
            fetch_cnt <= '0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nx;
            halt_cnt  <= halt_nx;
            cycle_cnt <= cycle_nx;
            fetch_cnt <= fetch_nx;
            pass_q    <= pass_nx;
            fail_q    <= fail_nx;
            timeout_q <= timeout_nx;
        end
    end
endmodule

// File: tb/tb_godai_run_monitor.sv
// tb_godai_run_monitor: directed and random checks of two monitor instances (HALT_REPEAT 1 and 3) against a rule-level model
module tb_godai_run_monitor;
    localparam logic [31:0] SIG  = 32'hBD8528BE;
    localparam logic [31:0] HALT = 32'h0000006F;
    localparam logic [31:0] NOP  = 32'h00000013;
    localparam int          TMO  = 100;
    logic        clk = 0, rst = 0, enable_i = 0, instr_rvalid_i = 0, rf_we_i = 0;
    logic [31:0] instr_rdata_i = 0, rf_wdata_i = 0;
    logic [4:0]  rf_waddr_i = 0;
    logic [1:0]  done_w, pass_w, fail_w, tmo_w, armed_w;
    logic [31:0] cyc_w [2];
    logic [31:0] fet_w [2];
    int          rep [2] = '{1, 3};
    bit          m_act [2], m_arm [2], m_done [2], m_pass [2], m_fail [2], m_tmo [2];
    int          m_streak [2];
    int unsigned m_cyc [2], m_fet [2];
    int          errors = 0, checks = 0;
    always #5 clk = ~clk;
    godai_run_monitor #(.HALT_REPEAT(1), .TIMEOUT_CYCLES(TMO)) u1 (
        .clk(clk), .rst(rst), .enable_i(enable_i), .instr_rvalid_i(instr_rvalid_i),
        .instr_rdata_i(instr_rdata_i), .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i),
        .rf_wdata_i(rf_wdata_i), .done_o(done_w[0]), .pass_o(pass_w[0]), .fail_o(fail_w[0]),
        .timeout_o(tmo_w[0]), .armed_o(armed_w[0]), .cycle_count_o(cyc_w[0]), .fetch_count_o(fet_w[0]));
    godai_run_monitor #(.HALT_REPEAT(3), .TIMEOUT_CYCLES(TMO)) u3 (
        .clk(clk), .rst(rst), .enable_i(enable_i), .instr_rvalid_i(instr_rvalid_i),
        .instr_rdata_i(instr_rdata_i), .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i),
        .rf_wdata_i(rf_wdata_i), .done_o(done_w[1]), .pass_o(pass_w[1]), .fail_o(fail_w[1]),
        .timeout_o(tmo_w[1]), .armed_o(armed_w[1]), .cycle_count_o(cyc_w[1]), .fetch_count_o(fet_w[1]));
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 0; m_arm[k] = 0; m_done[k] = 0; m_pass[k] = 0; m_fail[k] = 0; m_tmo[k] = 0;
            m_streak[k] = 0; m_cyc[k] = 0; m_fet[k] = 0;
        end
    endtask
    // one clock of the run rules: a write to r13 decides armed-ness first, then the halt streak is judged
    task automatic model_step();
        bit wr, hit, arm_n;
        int st_n;
        for (int k = 0; k < 2; k++) begin
            if (m_done[k] || !enable_i) continue;
            if (!m_act[k]) begin
                m_act[k] = 1;
                continue;
            end
            wr    = rf_we_i && rf_waddr_i == 5'd13;
            hit   = wr && rf_wdata_i == SIG;
            arm_n = hit ? 1'b1 : wr ? 1'b0 : m_arm[k];
            st_n  = !instr_rvalid_i ? m_streak[k] : instr_rdata_i == HALT ? m_streak[k] + 1 : 0;
            m_cyc[k]++;
            if (instr_rvalid_i) m_fet[k]++;
            if (st_n == rep[k]) begin
                m_done[k] = 1; m_pass[k] = arm_n; m_fail[k] = !arm_n; m_arm[k] = 0;
`ifdef GODAI_RUN_MONITOR_TIMEOUT_EN
            end else if (m_cyc[k] == TMO) begin
                m_done[k] = 1; m_fail[k] = 1; m_tmo[k] = 1; m_arm[k] = 0;
`endif
            end else begin
                m_streak[k] = (arm_n != m_arm[k]) ? 0 : st_n;
                m_arm[k] = arm_n;
            end
        end
    endtask
    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d_done", rep[k]), 32'(done_w[k]), 32'(m_done[k]));
            chk($sformatf("u%0d_pass", rep[k]), 32'(pass_w[k]), 32'(m_pass[k]));
            chk($sformatf("u%0d_fail", rep[k]), 32'(fail_w[k]), 32'(m_fail[k]));
            chk($sformatf("u%0d_timeout", rep[k]), 32'(tmo_w[k]), 32'(m_tmo[k]));
            chk($sformatf("u%0d_armed", rep[k]), 32'(armed_w[k]), 32'(m_arm[k]));
            chk($sformatf("u%0d_cycles", rep[k]), cyc_w[k], m_cyc[k]);
            chk($sformatf("u%0d_fetches", rep[k]), fet_w[k], m_fet[k]);
        end
    endtask
    task automatic step(bit en, bit rv, logic [31:0] rd, bit we, logic [4:0] wa, logic [31:0] wd);
        enable_i = en; instr_rvalid_i = rv; instr_rdata_i = rd;
        rf_we_i = we; rf_waddr_i = wa; rf_wdata_i = wd;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask
    task automatic nop(bit en);
        step(en, 0, 0, 0, 0, 0);
    endtask
    task automatic beat(logic [31:0] d);
        step(1, 1, d, 0, 0, 0);
    endtask
    task automatic wr(logic [4:0] a, logic [31:0] d);
        step(1, 0, 0, 1, a, d);
    endtask
    // asserts reset between edges and checks the outputs cleared before any clock edge
    task automatic do_reset();
        enable_i = 0; instr_rvalid_i = 0; rf_we_i = 0;
        #2 rst = 1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #2 rst = 0;
        #1;
    endtask
    initial begin
        do_reset();
        // signature then a single halt beat
        nop(1);
        wr(13, SIG);
        chk("a_armed", 32'(armed_w[0]), 32'd1);
        beat(HALT);
        chk("a_done", 32'(done_w[0]), 32'd1);
        chk("a_pass", 32'(pass_w[0]), 32'd1);
        // interrupted halt streak with HALT_REPEAT=3
        do_reset();
        nop(1);
        wr(13, SIG);
        beat(HALT); beat(HALT); beat(NOP); beat(HALT); beat(HALT);
        chk("b_not_done", 32'(done_w[1]), 32'd0);
        beat(HALT);
        chk("b_done", 32'(done_w[1]), 32'd1);
        chk("b_pass", 32'(pass_w[1]), 32'd1);
        chk("b_fetch", fet_w[1], 32'd6);
        // signature overwritten before halting
        do_reset();
        nop(1);
        wr(13, SIG);
        wr(13, 32'd0);
        chk("c_armed_fall", 32'(armed_w[0]), 32'd0);
        beat(HALT);
        chk("c_fail", 32'(fail_w[0]), 32'd1);
        chk("c_pass", 32'(pass_w[0]), 32'd0);
        // signature and final halt beat together
        do_reset();
        nop(1);
        step(1, 1, HALT, 1, 13, SIG);
        chk("d_pass", 32'(pass_w[0]), 32'd1);
        // watchdog
        do_reset();
        nop(1);
        repeat (120) nop(1);
`ifdef GODAI_RUN_MONITOR_TIMEOUT_EN
        chk("e_timeout", 32'(tmo_w[0]), 32'd1);
        chk("e_fail", 32'(fail_w[0]), 32'd1);
        chk("e_cycles", cyc_w[0], 32'd100);
`else
        chk("e_done", 32'(done_w[0]), 32'd0);
        chk("e_timeout", 32'(tmo_w[0]), 32'd0);
        chk("e_cycles", cyc_w[0], 32'd120);
`endif
        // pause holds everything, then asynchronous reset mid-run
        do_reset();
        nop(1);
        repeat (5) beat(NOP);
        repeat (10) step(0, 1'($urandom_range(0, 1)), HALT, 1, 13, SIG);
        chk("f_cycles_hold", cyc_w[0], 32'd5);
        chk("f_fetch_hold", fet_w[1], 32'd5);
        chk("f_not_done", 32'(done_w[0]), 32'd0);
        do_reset();
        nop(0);
        nop(1);
        nop(1);
        chk("f_restart_cycles", cyc_w[0], 32'd1);
        // random runs against the model
        repeat (12) begin
            do_reset();
            nop(1);
            repeat (40)
                step($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 9) < 6 ? HALT : $urandom,
                     1'($urandom_range(0, 1)),
                     $urandom_range(0, 1) == 1 ? 5'd13 : 5'($urandom),
                     $urandom_range(0, 1) == 1 ? SIG : $urandom);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
